// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out word serializer.
//   state_e  : serializer FSM encoding
//   GAP_W    : width of the inter-word gap counter (covers GAP_CYCLES up to 15)
//   cnt_w()  : width of the bit counter for a given word width
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int unsigned GAP_W = 4;

  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry word buffer with full flag.
//   CLK, RST : clock, synchronous active-high reset
//   load     : capture din and mark full
//   drain    : mark empty (word consumed by the shifter)
//   din      : word to capture
//   full     : buffer holds a word
//   dout     : buffered word
module word_hold_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = din;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/piso_serializer.sv
// Word serializer feeding the serial D input of a downstream shift register.
// Words arrive over valid/ready into a one-entry hold buffer and leave MSB-first,
// one bit per clock, with optional idle bit-times between words.
//   CLK, RST    : clock, synchronous active-high reset
//   din         : parallel word, taken when din_valid && din_ready
//   din_valid   : din holds a valid word
//   din_ready   : hold buffer empty (registered, no path from din_valid)
//   sout        : registered serial bit
//   sout_active : sout carries a data bit this cycle
//   word_done   : 1-cycle pulse, downstream register now holds the full word
//   busy        : hold buffer full or FSM not idle
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_active,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned        CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shifter_q, shifter_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               sout_q, sout_d;
  logic               done_q, done_d;

  logic               hold_full;
  logic [WIDTH-1:0]   hold_data;
  logic               accept;
  logic               drain;
  logic               start;

  assign accept = din_valid && !hold_full;

  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .CLK   (CLK),
    .RST   (RST),
    .load  (accept),
    .drain (drain),
    .din   (din),
    .full  (hold_full),
    .dout  (hold_data)
  );

  // The shifter keeps only the bits not yet on sout: the MSB goes straight to
  // sout_q at load time, so the last data bit is already out when cnt hits
  // CNT_LAST and that edge is free to start the next word or the gap.
  always_comb begin
    state_d   = state_q;
    shifter_d = shifter_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    sout_d    = IDLE_LEVEL;
    done_d    = 1'b0;
    start     = 1'b0;
    drain     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        start = hold_full;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            start = hold_full;
            if (!hold_full) state_d = ST_IDLE;
          end
        end else begin
          sout_d    = shifter_q[WIDTH-1];
          shifter_d = {shifter_q[WIDTH-2:0], 1'b0};
          cnt_d     = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          start = hold_full;
          if (!hold_full) state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start) begin
      drain     = 1'b1;
      state_d   = ST_SHIFT;
      sout_d    = hold_data[WIDTH-1];
      shifter_d = {hold_data[WIDTH-2:0], 1'b0};
      cnt_d     = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      shifter_q <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      sout_q    <= IDLE_LEVEL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shifter_q <= shifter_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      sout_q    <= sout_d;
      done_q    <= done_d;
    end
  end

  assign din_ready   = !hold_full;
  assign sout        = sout_q;
  assign sout_active = (state_q == ST_SHIFT);
  assign word_done   = done_q;
  assign busy        = hold_full || (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one instance without gap, one with GAP_CYCLES=2.
// Accepted words are pushed to bit and word queues; sout and the downstream
// register contents are compared against them as the DUT produces output.
module tb_piso_serializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] d0 = '0, d2 = '0;
  logic       v0 = 1'b0, v2 = 1'b0;
  logic       rdy0, so0, act0, wd0, bsy0;
  logic       rdy2, so2, act2, wd2, bsy2;
  logic [3:0] ds0 = '0, ds2 = '0;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  logic       bq0[$], bq2[$];
  logic [3:0] wq0[$], wq2[$];
  int unsigned wdc0[$], wdc2[$];
  int unsigned nact0, first0, last0, nact2, first2, last2;

  always #5 CLK = ~CLK;

  piso_serializer #(.WIDTH(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .din(d0), .din_valid(v0), .din_ready(rdy0),
    .sout(so0), .sout_active(act0), .word_done(wd0), .busy(bsy0)
  );

  piso_serializer #(.WIDTH(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut2 (
    .CLK(CLK), .RST(RST), .din(d2), .din_valid(v2), .din_ready(rdy2),
    .sout(so2), .sout_active(act2), .word_done(wd2), .busy(bsy2)
  );

  // Downstream 4-bit shift registers fed by sout.
  always @(posedge CLK) begin
    ds0 <= {ds0[2:0], so0};
    ds2 <= {ds2[2:0], so2};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    wdc0.delete(); wdc2.delete();
    nact0 = 0; first0 = 0; last0 = 0;
    nact2 = 0; first2 = 0; last2 = 0;
  endtask

  task automatic tick();
    logic       a0, a2, r;
    logic [3:0] c0, c2;
    logic       eb;
    logic [3:0] ew;
    a0 = v0 && rdy0; a2 = v2 && rdy2;
    c0 = d0; c2 = d2; r = RST;
    @(posedge CLK); #1;
    cyc++;
    if (r) begin
      bq0.delete(); wq0.delete(); bq2.delete(); wq2.delete();
    end else begin
      if (a0) begin
        for (int i = 3; i >= 0; i--) bq0.push_back(c0[i]);
        wq0.push_back(c0);
      end
      if (a2) begin
        for (int i = 3; i >= 0; i--) bq2.push_back(c2[i]);
        wq2.push_back(c2);
      end
    end
    if (act0) begin
      eb = (bq0.size() != 0) ? bq0.pop_front() : 1'bx;
      check("sout0_bit", so0, eb);
      if (first0 == 0) first0 = cyc;
      last0 = cyc; nact0++;
    end else check("sout0_idle", so0, 1'b0);
    if (wd0) begin
      ew = (wq0.size() != 0) ? wq0.pop_front() : 4'bxxxx;
      check("word0", ds0, ew);
      wdc0.push_back(cyc);
    end
    if (act2) begin
      eb = (bq2.size() != 0) ? bq2.pop_front() : 1'bx;
      check("sout2_bit", so2, eb);
      if (first2 == 0) first2 = cyc;
      last2 = cyc; nact2++;
    end else check("sout2_idle", so2, 1'b0);
    if (wd2) begin
      ew = (wq2.size() != 0) ? wq2.pop_front() : 4'bxxxx;
      check("word2", ds2, ew);
      wdc2.push_back(cyc);
    end
  endtask

  task automatic stream(input bit sel, input logic [3:0] w [4], input int unsigned n,
                        output int unsigned stalls);
    int unsigned idx;
    int unsigned guard;
    logic        acc;
    idx = 0; guard = 0; stalls = 0;
    while (idx < n && guard < 100) begin
      if (sel) begin d2 = w[idx]; v2 = 1'b1; acc = rdy2; end
      else     begin d0 = w[idx]; v0 = 1'b1; acc = rdy0; end
      if (!acc) stalls++;
      tick();
      guard++;
      if (acc) idx++;
    end
    v0 = 1'b0; v2 = 1'b0;
    check("stream_accepts", idx, n);
  endtask

  task automatic drain_all(input int unsigned bound);
    int unsigned n;
    n = 0;
    while ((wq0.size() != 0 || wq2.size() != 0 || bsy0 || bsy2) && n < bound) begin
      tick();
      n++;
    end
    check("drain_words_left", wq0.size() + wq2.size(), 0);
    check("drain_busy", {bsy0, bsy2}, 2'b00);
  endtask

  initial begin : main
    logic [3:0]  wl [4];
    logic [3:0]  pat;
    int unsigned st;

    // Reset, idle
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    check("rst_ready",  rdy0, 1'b1);
    check("rst_sout",   so0,  1'b0);
    check("rst_active", act0, 1'b0);
    check("rst_done",   wd0,  1'b0);
    check("rst_busy",   bsy0, 1'b0);
    check("rst_ready2", rdy2, 1'b1);
    check("rst_busy2",  bsy2, 1'b0);

    // Single word, exact latency
    clr_stats();
    pat = 4'b1011;
    d0 = pat; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i <= 4) check("single_sout", so0, pat[4-i]);
      check("single_done", wd0, (i == 5));
      if (i == 5) check("single_ds", ds0, 4'b1011);
    end
    drain_all(20);

    // Streaming, no gap
    clr_stats();
    wl = '{4'hA, 4'h5, 4'hF, 4'h0};
    stream(1'b0, wl, 3, st);
    drain_all(40);
    check("stream_active_cycles", nact0, 12);
    check("stream_contiguous", last0 - first0 + 1, 12);
    check("stream_done_count", wdc0.size(), 3);
    if (wdc0.size() == 3) begin
      check("stream_done_gap1", wdc0[1] - wdc0[0], 4);
      check("stream_done_gap2", wdc0[2] - wdc0[1], 4);
    end

    // Backpressure: valid held while the hold buffer is full
    clr_stats();
    wl = '{4'h6, 4'h9, 4'hC, 4'h3};
    stream(1'b0, wl, 4, st);
    check("bp_stall_cycles", st, 7);
    drain_all(40);
    check("bp_done_count", wdc0.size(), 4);

    // Gap of two idle bit-times between words
    clr_stats();
    wl = '{4'h9, 4'h6, 4'h0, 4'h0};
    stream(1'b1, wl, 2, st);
    drain_all(40);
    check("gap_active_cycles", nact2, 8);
    check("gap_idle_between", (last2 - first2 + 1) - nact2, 2);
    check("gap_done_count", wdc2.size(), 2);

    // Reset mid-word: in-flight 4'hC and buffered 4'h5 are dropped
    clr_stats();
    d0 = 4'hC; v0 = 1'b1;
    tick();
    d0 = 4'h5;
    tick();
    tick();
    v0 = 1'b0;
    check("midrst_active_before", act0, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("midrst_ready",  rdy0, 1'b1);
    check("midrst_sout",   so0,  1'b0);
    check("midrst_active", act0, 1'b0);
    check("midrst_busy",   bsy0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_done", wd0, 1'b0);
    end
    clr_stats();
    wl = '{4'h3, 4'h0, 4'h0, 4'h0};
    stream(1'b0, wl, 1, st);
    drain_all(20);
    check("midrst_new_word_done", wdc0.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
